cgol_frame_sink: RTL and testbench

- Receiving end of the cgol live-cell coordinate stream (8-bit row, 8-bit col per live cell, one generation at a time).
- Rebuilds each generation as a double-buffered bitmap and scans it out one grid row per handshake to a display/host port.
- Reports live-cell count, generation count and a sticky out-of-range error.
- Sits directly downstream of cgol on the same two-phase clock.

---
 rtl/cgol_pkg.sv | 25 ++
 rtl/cgol_frame_bank.sv | 54 +++++
 rtl/cgol_frame_sink.sv | 239 +++++++++++++++++++++++
 tb/tb_cgol_frame_sink.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cgol_pkg.sv
// Shared types and helpers for the cgol frame sink.
//   COORD_W    - width of the row/column coordinates on the input stream
//   wr_state_t - write-side FSM states
//   rd_state_t - read-side (scan-out) FSM states
//   addr_w()   - address width needed to index n entries (at least 1 bit)
package cgol_pkg;

  localparam int COORD_W = 8;

  typedef enum logic [1:0] {
    CLEAR,
    FILL,
    WAIT
  } wr_state_t;

  typedef enum logic {
    IDLE,
    SCAN
  } rd_state_t;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cgol_frame_bank.sv
// One GRID_ROWS x GRID_COLS bitmap bank.
// Ports:
//   clk              - update clock (ph2 of the two-phase pair)
//   reset            - synchronous, active-low; clears only the read register
//   clr_en, clr_row  - zero one whole row
//   set_en, set_row,
//   set_col          - set one bit
//   set_old          - current value of bit (set_row, set_col), before any set
//   rd_en, rd_row    - registered row read; rd_data holds when rd_en=0
//   rd_data          - registered row contents, bit c = column c
module cgol_frame_bank
  import cgol_pkg::*;
#(
  parameter int GRID_ROWS = 16,
  parameter int GRID_COLS = 16,
  parameter int ROW_AW    = addr_w(GRID_ROWS),
  parameter int COL_AW    = addr_w(GRID_COLS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr_en,
  input  logic [ROW_AW-1:0]    clr_row,
  input  logic                 set_en,
  input  logic [ROW_AW-1:0]    set_row,
  input  logic [COL_AW-1:0]    set_col,
  output logic                 set_old,
  input  logic                 rd_en,
  input  logic [ROW_AW-1:0]    rd_row,
  output logic [GRID_COLS-1:0] rd_data
);

  // Storage is not reset: the write side sweeps every row through CLEAR
  // before a bank is ever filled and handed to the reader.
  logic [GRID_COLS-1:0] mem [GRID_ROWS];

  assign set_old = mem[set_row][set_col];

  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_row] <= '0;
    end else if (set_en) begin
      mem[set_row][set_col] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_row];
    end
  end

endmodule

// File: rtl/cgol_frame_sink.sv
// Receives the cgol live-cell coordinate stream, rebuilds each generation in
// a double-buffered bitmap and scans finished frames out one row per
// handshake.
// Ports:
//   ph1, ph2          - non-overlapping two-phase clock; inputs captured on
//                       ph1, state and outputs updated on ph2
//   reset             - synchronous, active-low
//   in_valid/in_ready - coordinate/marker beat handshake
//   in_row, in_col    - live-cell coordinate
//   in_eog            - end-of-generation marker (coordinate ignored)
//   rd_valid/rd_ready - row scan-out handshake
//   rd_row_idx        - row index on rd_bits
//   rd_bits           - row contents, bit c = column c
//   gen_count         - completed generations (wraps)
//   live_count        - live cells in the frame being scanned
//   oor_err           - sticky out-of-range coordinate flag
module cgol_frame_sink
  import cgol_pkg::*;
#(
  parameter int GRID_ROWS = 16,
  parameter int GRID_COLS = 16,
  parameter int CNT_W     = 16
) (
  input  logic                 ph1,
  input  logic                 ph2,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [COORD_W-1:0]   in_row,
  input  logic [COORD_W-1:0]   in_col,
  input  logic                 in_eog,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [COORD_W-1:0]   rd_row_idx,
  output logic [GRID_COLS-1:0] rd_bits,
  output logic [CNT_W-1:0]     gen_count,
  output logic [CNT_W-1:0]     live_count,
  output logic                 oor_err
);

  // state | meaning
  // CLEAR | zeroing write bank, one row per cycle
  // FILL  | accepting coordinates into the write bank
  // WAIT  | generation complete, waiting for reader to finish its frame
  // IDLE  | reader has no frame
  // SCAN  | reader presenting rows of the read bank

  localparam int ROW_AW = addr_w(GRID_ROWS);
  localparam int COL_AW = addr_w(GRID_COLS);
  localparam logic [COORD_W:0]   ROWS_LIM = (COORD_W + 1)'(GRID_ROWS);
  localparam logic [COORD_W:0]   COLS_LIM = (COORD_W + 1)'(GRID_COLS);
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(GRID_ROWS - 1);

  // ph1 input capture
  logic               reset_q;
  logic               in_valid_q;
  logic               in_eog_q;
  logic               rd_ready_q;
  logic [COORD_W-1:0] in_row_q;
  logic [COORD_W-1:0] in_col_q;

  always_ff @(posedge ph1) begin
    reset_q    <= reset;
    in_valid_q <= in_valid;
    in_eog_q   <= in_eog;
    rd_ready_q <= rd_ready;
    in_row_q   <= in_row;
    in_col_q   <= in_col;
  end

  // ph2 state
  wr_state_t          wr_state, wr_state_nxt;
  rd_state_t          rd_state, rd_state_nxt;
  logic [COORD_W-1:0] wr_row, wr_row_nxt;
  logic [COORD_W-1:0] rd_idx, rd_idx_nxt;
  logic [CNT_W-1:0]   run_count, run_count_nxt;
  logic [CNT_W-1:0]   gen_q, gen_nxt;
  logic [CNT_W-1:0]   live_q, live_nxt;
  logic               oor_q, oor_nxt;
  // bank_sel names the read bank; the other one is the write bank
  logic               bank_sel, bank_sel_nxt;

  logic                 beat, coord_ok, rd_last_hs, swap;
  logic                 clr_en, set_en, set_old;
  logic                 set_old0, set_old1;
  logic [GRID_COLS-1:0] rd_data0, rd_data1;

  assign in_ready   = (wr_state == FILL);
  assign rd_valid   = (rd_state == SCAN);
  assign rd_row_idx = rd_idx;
  assign rd_bits    = bank_sel ? rd_data1 : rd_data0;
  assign gen_count  = gen_q;
  assign live_count = live_q;
  assign oor_err    = oor_q;

  assign beat       = in_valid_q && in_ready;
  assign coord_ok   = ({1'b0, in_row_q} < ROWS_LIM) && ({1'b0, in_col_q} < COLS_LIM);
  assign rd_last_hs = rd_valid && rd_ready_q && (rd_idx == LAST_ROW);
  assign set_old    = bank_sel ? set_old0 : set_old1;

  always_comb begin
    wr_state_nxt  = wr_state;
    rd_state_nxt  = rd_state;
    wr_row_nxt    = wr_row;
    rd_idx_nxt    = rd_idx;
    run_count_nxt = run_count;
    gen_nxt       = gen_q;
    live_nxt      = live_q;
    oor_nxt       = oor_q;
    bank_sel_nxt  = bank_sel;
    clr_en        = 1'b0;
    set_en        = 1'b0;
    swap          = 1'b0;

    case (wr_state)
      CLEAR: begin
        clr_en = 1'b1;
        if (wr_row == LAST_ROW) begin
          wr_state_nxt  = FILL;
          run_count_nxt = '0;
        end else begin
          wr_row_nxt = wr_row + 1'b1;
        end
      end
      FILL: begin
        if (beat) begin
          if (in_eog_q) begin
            // a reader releasing its last row this cycle counts as idle
            if (rd_state == IDLE || rd_last_hs) begin
              swap = 1'b1;
            end else begin
              wr_state_nxt = WAIT;
            end
          end else if (coord_ok) begin
            set_en = 1'b1;
            if (!set_old) begin
              run_count_nxt = run_count + 1'b1;
            end
          end else begin
            oor_nxt = 1'b1;
          end
        end
      end
      WAIT: begin
        if (rd_last_hs) begin
          swap = 1'b1;
        end
      end
      default: wr_state_nxt = CLEAR;
    endcase

    if (rd_valid && rd_ready_q) begin
      if (rd_idx == LAST_ROW) begin
        rd_state_nxt = IDLE;
        rd_idx_nxt   = '0;
      end else begin
        rd_idx_nxt = rd_idx + 1'b1;
      end
    end

    if (swap) begin
      wr_state_nxt = CLEAR;
      wr_row_nxt   = '0;
      bank_sel_nxt = ~bank_sel;
      live_nxt     = run_count;
      gen_nxt      = gen_q + 1'b1;
      rd_state_nxt = SCAN;
      rd_idx_nxt   = '0;
    end
  end

  always_ff @(posedge ph2) begin
    if (!reset_q) begin
      wr_state  <= CLEAR;
      rd_state  <= IDLE;
      wr_row    <= '0;
      rd_idx    <= '0;
      run_count <= '0;
      gen_q     <= '0;
      live_q    <= '0;
      oor_q     <= 1'b0;
      bank_sel  <= 1'b0;
    end else begin
      wr_state  <= wr_state_nxt;
      rd_state  <= rd_state_nxt;
      wr_row    <= wr_row_nxt;
      rd_idx    <= rd_idx_nxt;
      run_count <= run_count_nxt;
      gen_q     <= gen_nxt;
      live_q    <= live_nxt;
      oor_q     <= oor_nxt;
      bank_sel  <= bank_sel_nxt;
    end
  end

  // Both banks read the row the reader will present next cycle; the
  // registered bank_sel then picks the one that is the read bank.
  logic rd_en;
  assign rd_en = (rd_state_nxt == SCAN);

  cgol_frame_bank #(
    .GRID_ROWS(GRID_ROWS),
    .GRID_COLS(GRID_COLS),
    .ROW_AW   (ROW_AW),
    .COL_AW   (COL_AW)
  ) u_bank0 (
    .clk    (ph2),
    .reset  (reset_q),
    .clr_en (clr_en && bank_sel),
    .clr_row(wr_row[ROW_AW-1:0]),
    .set_en (set_en && bank_sel),
    .set_row(in_row_q[ROW_AW-1:0]),
    .set_col(in_col_q[COL_AW-1:0]),
    .set_old(set_old0),
    .rd_en  (rd_en),
    .rd_row (rd_idx_nxt[ROW_AW-1:0]),
    .rd_data(rd_data0)
  );

  cgol_frame_bank #(
    .GRID_ROWS(GRID_ROWS),
    .GRID_COLS(GRID_COLS),
    .ROW_AW   (ROW_AW),
    .COL_AW   (COL_AW)
  ) u_bank1 (
    .clk    (ph2),
    .reset  (reset_q),
    .clr_en (clr_en && !bank_sel),
    .clr_row(wr_row[ROW_AW-1:0]),
    .set_en (set_en && !bank_sel),
    .set_row(in_row_q[ROW_AW-1:0]),
    .set_col(in_col_q[COL_AW-1:0]),
    .set_old(set_old1),
    .rd_en  (rd_en),
    .rd_row (rd_idx_nxt[ROW_AW-1:0]),
    .rd_data(rd_data1)
  );

endmodule

// File: tb/tb_cgol_frame_sink.sv
module tb_cgol_frame_sink;
  localparam int R = 16;
  localparam int C = 16;
  localparam int W = 16;

  logic         ph1, ph2, reset;
  logic         in_valid, in_ready, in_eog;
  logic [7:0]   in_row, in_col, rd_row_idx;
  logic         rd_valid, rd_ready, oor_err;
  logic [C-1:0] rd_bits;
  logic [W-1:0] gen_count, live_count;

  cgol_frame_sink #(.GRID_ROWS(R), .GRID_COLS(C), .CNT_W(W)) dut (
    .ph1       (ph1),
    .ph2       (ph2),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .in_col    (in_col),
    .in_eog    (in_eog),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_row_idx(rd_row_idx),
    .rd_bits   (rd_bits),
    .gen_count (gen_count),
    .live_count(live_count),
    .oor_err   (oor_err)
  );

  // period 20: ph1 high [2,8), ph2 high [12,18)
  initial begin
    ph1 = 0;
    ph2 = 0;
    forever begin
      #2 ph1 = 1;
      #6 ph1 = 0;
      #4 ph2 = 1;
      #6 ph2 = 0;
      #2;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]   idx;
    logic [C-1:0] bits;
    logic [W-1:0] live;
    logic [W-1:0] gen;
  } exp_t;

  exp_t         sbq[$];
  logic [C-1:0] mdl [R];
  int           mdl_live;
  int           mgen;
  logic         moor;
  int           total;
  int           bad;
  logic         in_acc;
  logic         prev_last;
  int           n;
  logic [C-1:0] held_bits;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < R; i++) mdl[i] = '0;
    mdl_live = 0;
  endtask

  // Evaluate this cycle's handshakes against the visible outputs, then
  // advance to the next cycle's outputs.
  task automatic tick();
    exp_t e;
    in_acc = in_valid && (in_ready === 1'b1);
    if (prev_last && sbq.size() > 0) begin
      chk("restart_valid", rd_valid, 1);
      chk("restart_idx", rd_row_idx, 0);
    end
    prev_last = 0;
    if (rd_valid === 1'b1 && rd_ready) begin
      if (sbq.size() == 0) begin
        chk("spurious_rd_valid", rd_valid, 0);
      end else begin
        e = sbq.pop_front();
        chk("row_idx", rd_row_idx, e.idx);
        chk("row_bits", rd_bits, e.bits);
        chk("live_count", live_count, e.live);
        chk("gen_count", gen_count, e.gen);
        prev_last = (e.idx == 8'(R - 1));
      end
    end
    @(negedge ph2);
    #1;
  endtask

  task automatic send(input logic [7:0] r, input logic [7:0] c, input logic eog);
    exp_t e;
    in_valid = 1;
    in_row   = r;
    in_col   = c;
    in_eog   = eog;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (in_acc) break;
    end
    in_valid = 0;
    in_eog   = 0;
    chk("beat_accept", in_acc, 1);
    if (in_acc) begin
      if (eog) begin
        for (int i = 0; i < R; i++) begin
          e.idx  = 8'(i);
          e.bits = mdl[i];
          e.live = W'(mdl_live);
          e.gen  = W'(mgen + 1);
          sbq.push_back(e);
        end
        mgen++;
        mdl_clear();
      end else if (r < R && c < C) begin
        if (!mdl[r][c]) mdl_live++;
        mdl[r][c] = 1'b1;
      end else begin
        moor = 1'b1;
      end
    end
  endtask

  task automatic drain();
    rd_ready = 1;
    for (int k = 0; k < 400 && sbq.size() > 0; k++) tick();
    chk("drain_empty", sbq.size(), 0);
    chk("idle_after_drain", rd_valid, 0);
  endtask

  task automatic count_clear(input string tag);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      if (in_ready === 1'b1) break;
      n++;
      tick();
    end
    chk(tag, n, 16);
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_row_idx", rd_row_idx, 0);
    chk("rst_rd_bits", rd_bits, 0);
    chk("rst_gen_count", gen_count, 0);
    chk("rst_live_count", live_count, 0);
    chk("rst_oor_err", oor_err, 0);
  endtask

  initial begin
    reset     = 0;
    in_valid  = 0;
    in_row    = 0;
    in_col    = 0;
    in_eog    = 0;
    rd_ready  = 0;
    total     = 0;
    bad       = 0;
    prev_last = 0;
    mgen      = 0;
    moor      = 0;
    mdl_clear();

    // power-on reset
    tick();
    tick();
    chk_reset_vals();
    reset = 1;
    count_clear("clear_after_reset");

    // generation 1 plus swap timing with an idle reader
    rd_ready = 1;
    send(8'd1, 8'd2, 0);
    send(8'd2, 8'd3, 0);
    send(8'd3, 8'd1, 0);
    send(8'd3, 8'd2, 0);
    send(8'd3, 8'd3, 0);
    send(8'd0, 8'd0, 1);
    chk("swap_rd_valid", rd_valid, 1);
    chk("swap_rd_idx", rd_row_idx, 0);
    chk("swap_in_ready", in_ready, 0);
    count_clear("clear_after_swap");
    drain();
    chk("gen_after_g1", gen_count, mgen);

    // empty generation
    send(8'd0, 8'd0, 1);
    drain();

    // duplicates and out-of-range coordinates
    send(8'd5, 8'd5, 0);
    send(8'd5, 8'd5, 0);
    send(8'd20, 8'd0, 0);
    send(8'd0, 8'd16, 0);
    send(8'd0, 8'd0, 1);
    drain();
    chk("oor_set", oor_err, moor);
    send(8'd0, 8'd0, 0);
    send(8'd0, 8'd0, 1);
    drain();
    chk("oor_sticky", oor_err, 1);

    // reader stalls at row 4 while the next generation completes
    rd_ready = 0;
    send(8'd4, 8'd9, 0);
    send(8'd15, 8'd15, 0);
    send(8'd1, 8'd1, 0);
    send(8'd0, 8'd0, 1);
    rd_ready = 1;
    repeat (4) tick();
    rd_ready = 0;
    chk("stall_idx", rd_row_idx, 4);
    held_bits = rd_bits;
    chk("stall_bits", held_bits, 16'h0200);
    send(8'd7, 8'd7, 0);
    send(8'd0, 8'd0, 1);
    for (int k = 0; k < 3; k++) begin
      chk("wait_in_ready", in_ready, 0);
      chk("hold_valid", rd_valid, 1);
      chk("hold_idx", rd_row_idx, 4);
      chk("hold_bits", rd_bits, held_bits);
      tick();
    end
    drain();

    // reset in the middle of a fill
    send(8'd2, 8'd2, 0);
    send(8'd6, 8'd1, 0);
    send(8'd9, 8'd3, 0);
    rd_ready = 0;
    reset = 0;
    tick();
    chk_reset_vals();
    sbq.delete();
    mdl_clear();
    mgen = 0;
    moor = 0;
    reset = 1;
    count_clear("clear_after_mid_reset");
    rd_ready = 1;
    send(8'd0, 8'd0, 1);
    drain();
    chk("gen_after_reset", gen_count, 1);
    chk("oor_after_reset", oor_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
